// File: rtl/ascon_pkg.sv
// Shared constants, FSM encoding and helpers for the ASCON permutation controller.
// Consumers: round, ascon_perm_ctrl_if, ascon_perm_ctrl (ASCON_PERM_UNROLL2_EN selects the two-round datapath).
package ascon_pkg;

   localparam int STATE_W    = 320;
   localparam int MAX_ROUNDS = 12;
   localparam int LANE_W     = 64;

   // Lane base offsets inside the packed state {x0,x1,x2,x3,x4}
   localparam int X0_LSB = 256;
   localparam int X1_LSB = 192;
   localparam int X2_LSB = 128;
   localparam int X3_LSB = 64;
   localparam int X4_LSB = 0;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } fsm_e;

   function automatic logic [7:0] rc(input logic [3:0] idx);
      return {4'd15 - idx, idx};
   endfunction

   // Out-of-range requests (0, 13..15) run the full permutation
   function automatic logic [3:0] n_eff(input logic [3:0] r);
      return ((r == 4'd0) || (r > 4'(MAX_ROUNDS))) ? 4'(MAX_ROUNDS) : r;
   endfunction

   function automatic logic [LANE_W-1:0] ror64(input logic [LANE_W-1:0] x, input int unsigned n);
      return (x >> n) | (x << (LANE_W - n));
   endfunction

endpackage

// File: rtl/ascon_perm_ctrl_if.sv
// Request/response bundle between the AEAD sequencer (master) and the permutation controller (slave).
interface ascon_perm_ctrl_if;

   logic                             start_i;
   logic [3:0]                       rounds_i;
   logic [ascon_pkg::STATE_W-1:0]    state_i;
   logic                             ready_o;
   logic                             busy_o;
   logic                             done_o;
   logic [ascon_pkg::STATE_W-1:0]    state_o;

   modport master (
      output start_i, rounds_i, state_i,
      input  ready_o, busy_o, done_o, state_o
   );

   modport slave (
      input  start_i, rounds_i, state_i,
      output ready_o, busy_o, done_o, state_o
   );

endinterface

// File: rtl/round.sv
// Combinational ASCON round: constant addition, bitsliced 5-bit S-box layer, linear diffusion layer.
module round
   import ascon_pkg::*;
(
   input  logic [STATE_W-1:0] s,
   input  logic [7:0]         C,
   output logic [STATE_W-1:0] s_rout
);

   always_comb begin
      logic [LANE_W-1:0] x0, x1, x2, x3, x4;
      logic [LANE_W-1:0] t0, t1, t2, t3, t4;
      // NOTE: blocking assignments make each S-box step see the value written by the step above it.
      x0 = s[X0_LSB +: LANE_W];
      x1 = s[X1_LSB +: LANE_W];
      x2 = s[X2_LSB +: LANE_W] ^ {{(LANE_W-8){1'b0}}, C};
      x3 = s[X3_LSB +: LANE_W];
      x4 = s[X4_LSB +: LANE_W];

      x0 = x0 ^ x4;
      x4 = x4 ^ x3;
      x2 = x2 ^ x1;
      t0 = ~x0 & x1;
      t1 = ~x1 & x2;
      t2 = ~x2 & x3;
      t3 = ~x3 & x4;
      t4 = ~x4 & x0;
      x0 = x0 ^ t1;
      x1 = x1 ^ t2;
      x2 = x2 ^ t3;
      x3 = x3 ^ t4;
      x4 = x4 ^ t0;
      x1 = x1 ^ x0;
      x0 = x0 ^ x4;
      x3 = x3 ^ x2;
      x2 = ~x2;

      s_rout = '0;
      s_rout[X0_LSB +: LANE_W] = x0 ^ ror64(x0, 19) ^ ror64(x0, 28);
      s_rout[X1_LSB +: LANE_W] = x1 ^ ror64(x1, 61) ^ ror64(x1, 39);
      s_rout[X2_LSB +: LANE_W] = x2 ^ ror64(x2, 1)  ^ ror64(x2, 6);
      s_rout[X3_LSB +: LANE_W] = x3 ^ ror64(x3, 10) ^ ror64(x3, 17);
      s_rout[X4_LSB +: LANE_W] = x4 ^ ror64(x4, 7)  ^ ror64(x4, 41);
   end

endmodule

// File: rtl/ascon_perm_ctrl.sv
// Iterative ASCON p^n controller: loads a state, applies rounds 12-n..11, returns the result with a done pulse.
// Define ASCON_PERM_UNROLL2_EN to chain two rounds per clock; handshake is unchanged.
module ascon_perm_ctrl
   import ascon_pkg::*;
(
   input  logic               clk,
   input  logic               rst,
   ascon_perm_ctrl_if.slave   bus
);

   fsm_e               fsm_q;
   logic [3:0]         idx_q;
   logic [STATE_W-1:0] state_q;
   logic [STATE_W-1:0] state_o_q;
   logic               ready_q;
   logic               busy_q;
   logic               done_q;

   logic [7:0]         rc0;
   logic [STATE_W-1:0] r0_out;
   logic [STATE_W-1:0] round_out;
   logic               last_round;

   assign rc0 = rc(idx_q);

   round u_round0 (
      .s      (state_q),
      .C      (rc0),
      .s_rout (r0_out)
   );

`ifdef ASCON_PERM_UNROLL2_EN
   localparam logic [3:0] IDX_STEP = 4'd2;

   logic [7:0]         rc1;
   logic [STATE_W-1:0] r1_out;
   logic               single_left;

   assign rc1 = rc(idx_q + 4'd1);

   round u_round1 (
      .s      (r0_out),
      .C      (rc1),
      .s_rout (r1_out)
   );

   // Odd round counts finish with only the first instance's result
   assign single_left = (idx_q == 4'(MAX_ROUNDS - 1));
   assign round_out   = single_left ? r0_out : r1_out;
   assign last_round  = (idx_q >= 4'(MAX_ROUNDS - 2));
`else
   localparam logic [3:0] IDX_STEP = 4'd1;

   assign round_out  = r0_out;
   assign last_round = (idx_q == 4'(MAX_ROUNDS - 1));
`endif

   // NOTE: all state updates use non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk) begin
      if (rst) begin
         fsm_q     <= IDLE;
         idx_q     <= '0;
         state_q   <= '0;
         state_o_q <= '0;
         ready_q   <= 1'b1;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
      end else begin
         done_q <= 1'b0;
         unique case (fsm_q)
            IDLE, DONE: begin
               if (bus.start_i) begin
                  state_q <= bus.state_i;
                  idx_q   <= 4'(MAX_ROUNDS) - n_eff(bus.rounds_i);
                  fsm_q   <= RUN;
                  ready_q <= 1'b0;
                  busy_q  <= 1'b1;
               end else begin
                  fsm_q <= IDLE;
               end
            end
            RUN: begin
               state_q <= round_out;
               idx_q   <= idx_q + IDX_STEP;
               if (last_round) begin
                  fsm_q     <= DONE;
                  state_o_q <= round_out;
                  ready_q   <= 1'b1;
                  busy_q    <= 1'b0;
                  done_q    <= 1'b1;
               end
            end
            default: fsm_q <= IDLE;
         endcase
      end
   end

   assign bus.ready_o = ready_q;
   assign bus.busy_o  = busy_q;
   assign bus.done_o  = done_q;
   assign bus.state_o = state_o_q;

endmodule

// File: tb/tb_ascon_perm_ctrl.sv
// Directed bench for ascon_perm_ctrl: reference round uses the ASCON S-box table and per-bit rotations.
module tb_ascon_perm_ctrl;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   ascon_perm_ctrl_if bus ();

   ascon_perm_ctrl dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   localparam logic [4:0] SBOX [32] = '{
      5'h04, 5'h0b, 5'h1f, 5'h14, 5'h1a, 5'h15, 5'h09, 5'h02,
      5'h1b, 5'h05, 5'h08, 5'h12, 5'h1d, 5'h03, 5'h06, 5'h1c,
      5'h1e, 5'h13, 5'h07, 5'h0e, 5'h00, 5'h0d, 5'h11, 5'h18,
      5'h10, 5'h0c, 5'h01, 5'h19, 5'h16, 5'h0a, 5'h0f, 5'h17
   };
   localparam logic [7:0] RC_TAB [12] = '{
      8'hF0, 8'hE1, 8'hD2, 8'hC3, 8'hB4, 8'hA5,
      8'h96, 8'h87, 8'h78, 8'h69, 8'h5A, 8'h4B
   };
   localparam int ROT1 [5] = '{19, 61, 1, 10, 7};
   localparam int ROT2 [5] = '{28, 39, 6, 17, 41};

   localparam logic [319:0] SA = {64'h0123456789abcdef, 64'hfedcba9876543210,
                                  64'h0f1e2d3c4b5a6978, 64'h8877665544332211,
                                  64'hdeadbeefcafef00d};
   localparam logic [319:0] SB = {64'h1111111111111111, 64'h8000000000000001,
                                  64'h00000000000000ff, 64'hffffffff00000000,
                                  64'h5555aaaa5555aaaa};

   int n_cmp = 0;
   int n_mis = 0;

   task automatic check(input string tag, input logic [319:0] got, input logic [319:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_mis++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   function automatic logic [319:0] model_round(input logic [319:0] st, input logic [7:0] c);
      logic [63:0]  x [5];
      logic [63:0]  y [5];
      logic [63:0]  z [5];
      logic [4:0]   col;
      logic [4:0]   o;
      logic [319:0] r;
      for (int i = 0; i < 5; i++) x[i] = st[319-64*i -: 64];
      x[2][7:0] = x[2][7:0] ^ c;
      for (int b = 0; b < 64; b++) begin
         col = {x[0][b], x[1][b], x[2][b], x[3][b], x[4][b]};
         o   = SBOX[col];
         y[0][b] = o[4];
         y[1][b] = o[3];
         y[2][b] = o[2];
         y[3][b] = o[1];
         y[4][b] = o[0];
      end
      for (int i = 0; i < 5; i++)
         for (int b = 0; b < 64; b++)
            z[i][b] = y[i][b] ^ y[i][(b + ROT1[i]) % 64] ^ y[i][(b + ROT2[i]) % 64];
      for (int i = 0; i < 5; i++) r[319-64*i -: 64] = z[i];
      return r;
   endfunction

   function automatic logic [319:0] model_perm(input logic [319:0] st, input int n);
      logic [319:0] s = st;
      for (int k = 12 - n; k < 12; k++) s = model_round(s, RC_TAB[k]);
      return s;
   endfunction

   function automatic int exp_lat(input int n);
`ifdef ASCON_PERM_UNROLL2_EN
      return (n + 1) / 2;
`else
      return n;
`endif
   endfunction

   // Constants seen on the first round instance, one per busy cycle
   function automatic logic [95:0] exp_cseq(input int n);
      logic [95:0] e = '0;
`ifdef ASCON_PERM_UNROLL2_EN
      for (int k = 12 - n; k < 12; k += 2) e = {e[87:0], RC_TAB[k]};
`else
      for (int k = 12 - n; k < 12; k++) e = {e[87:0], RC_TAB[k]};
`endif
      return e;
   endfunction

   task automatic run_req(input logic [3:0] n, input logic [319:0] st,
                          output logic [319:0] res, output int lat, output logic [95:0] cseq);
      bus.start_i  = 1'b1;
      bus.rounds_i = n;
      bus.state_i  = st;
      @(negedge clk);
      bus.start_i = 1'b0;
      bus.state_i = ~st;
      lat  = -1;
      cseq = '0;
      for (int k = 1; k <= 40; k++) begin
         if (bus.busy_o) cseq = {cseq[87:0], dut.rc0};
         @(negedge clk);
         if (bus.done_o) begin
            lat = k;
            break;
         end
      end
      res = bus.state_o;
   endtask

   logic [319:0] res;
   logic [95:0]  cs;
   int           lat;
   int           gap;
   logic         seen_done;

   initial begin
      rst          = 1'b1;
      bus.start_i  = 1'b0;
      bus.rounds_i = 4'd0;
      bus.state_i  = '0;
      repeat (3) @(negedge clk);
      check("rst_ready", 320'(bus.ready_o), 320'd1);
      check("rst_busy",  320'(bus.busy_o),  320'd0);
      check("rst_done",  320'(bus.done_o),  320'd0);
      check("rst_state", bus.state_o,       320'd0);
      rst = 1'b0;
      @(negedge clk);

      // p^12 of the all-zero state
      run_req(4'd12, '0, res, lat, cs);
      check("p12_lat",  320'(lat), 320'(exp_lat(12)));
      check("p12_res",  res, model_perm('0, 12));
      check("p12_cseq", 320'(cs), 320'(exp_cseq(12)));
      @(negedge clk);
      check("p12_done_pulse", 320'(bus.done_o),  320'd0);
      check("p12_ready_idle", 320'(bus.ready_o), 320'd1);
      check("p12_state_held", bus.state_o, model_perm('0, 12));

      run_req(4'd6, SA, res, lat, cs);
      check("p6_lat",  320'(lat), 320'(exp_lat(6)));
      check("p6_res",  res, model_perm(SA, 6));
      check("p6_cseq", 320'(cs), 320'(exp_cseq(6)));

      run_req(4'd8, SB, res, lat, cs);
      check("p8_lat",  320'(lat), 320'(exp_lat(8)));
      check("p8_res",  res, model_perm(SB, 8));
      check("p8_cseq", 320'(cs), 320'(exp_cseq(8)));

      // start held through RUN: second state ignored, then accepted back-to-back in DONE
      bus.start_i  = 1'b1;
      bus.rounds_i = 4'd12;
      bus.state_i  = SA;
      @(negedge clk);
      bus.state_i = SB;
      check("hold_busy",  320'(bus.busy_o),  320'd1);
      check("hold_ready", 320'(bus.ready_o), 320'd0);
      lat = -1;
      for (int k = 1; k <= 40; k++) begin
         @(negedge clk);
         if (bus.done_o) begin
            lat = k;
            break;
         end
      end
      check("hold_lat",  320'(lat), 320'(exp_lat(12)));
      check("hold_res1", bus.state_o, model_perm(SA, 12));
      gap = -1;
      for (int j = 1; j <= 40; j++) begin
         @(negedge clk);
         if (j == 1) bus.start_i = 1'b0;
         if (bus.done_o) begin
            gap = j;
            break;
         end
      end
      check("b2b_gap",  320'(gap), 320'(exp_lat(12) + 1));
      check("b2b_res2", bus.state_o, model_perm(SB, 12));
      @(negedge clk);

      // Reset during round 5 of p^12
      bus.start_i  = 1'b1;
      bus.rounds_i = 4'd12;
      bus.state_i  = SA;
      @(negedge clk);
      bus.start_i = 1'b0;
      repeat (4) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check("abort_state", bus.state_o,       320'd0);
      check("abort_ready", 320'(bus.ready_o), 320'd1);
      check("abort_busy",  320'(bus.busy_o),  320'd0);
      seen_done = bus.done_o;
      for (int k = 0; k < 16; k++) begin
         @(negedge clk);
         seen_done = seen_done | bus.done_o;
      end
      check("abort_no_done", 320'(seen_done), 320'd0);
      run_req(4'd12, SA, res, lat, cs);
      check("fresh_lat", 320'(lat), 320'(exp_lat(12)));
      check("fresh_res", res, model_perm(SA, 12));

      // Clamped and minimal round counts
      run_req(4'd0, SB, res, lat, cs);
      check("r0_lat", 320'(lat), 320'(exp_lat(12)));
      check("r0_res", res, model_perm(SB, 12));
      run_req(4'd15, SB, res, lat, cs);
      check("r15_lat", 320'(lat), 320'(exp_lat(12)));
      check("r15_res", res, model_perm(SB, 12));
      run_req(4'd1, SA, res, lat, cs);
      check("r1_lat",  320'(lat), 320'(exp_lat(1)));
      check("r1_res",  res, model_round(SA, 8'h4B));
      check("r1_cseq", 320'(cs), 320'h4B);
      run_req(4'd7, SA, res, lat, cs);
      check("r7_lat",  320'(lat), 320'(exp_lat(7)));
      check("r7_res",  res, model_perm(SA, 7));
      check("r7_cseq", 320'(cs), 320'(exp_cseq(7)));

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
      $finish;
   end

endmodule

// File: doc/ascon_perm_ctrl.md
Name: ascon_perm_ctrl

Overview:
- Iterative controller for the ASCON permutation p^n built around the existing combinational 320-bit round datapath `round` (ports s, C, s_rout).
- Loads a state, then applies n rounds (one per clock by default) with the correct round constants. Returns the permuted state with a done pulse.
- Sits between the mode/AEAD sequencer (init, AD, data and finalisation phases) and the round datapath. Serves p^12, p^8 and p^6 requests.

Parameters:
- STATE_W, 320, permutation state width; fixed by ASCON, must not be overridden.
- MAX_ROUNDS, 12, maximum round count and constant-index base.

Ports:
- clk  input  1  system clock
- rst  input  1  synchronous, active-high reset
- start_i  input  1  request strobe; accepted only when ready_o=1
- rounds_i  input  4  round count n, sampled with start_i; legal 1..12
- state_i  input  320  state to permute, {x0,x1,x2,x3,x4}, x0 in [319:256]; sampled with start_i
- ready_o  output  1  controller can accept start_i this cycle
- busy_o  output  1  rounds in progress
- done_o  output  1  one-cycle pulse: state_o valid
- state_o  output  320  permuted state; held until next accept or reset

Behaviour:
- One clock. Reset is synchronous and active-high. Clock port is `clk`, reset port is `rst`.
- Reset values:
  - FSM=IDLE, ready_o=1, busy_o=0, done_o=0, state_o=0, round index idx=0.
- FSM states: IDLE, RUN, DONE.
- IDLE, start_i=1:
  - state_reg<=state_i; idx<=MAX_ROUNDS-n_eff; go to RUN.
  - n_eff=rounds_i if 1..12, else 12 (0 and 13..15 are clamped to 12).
- RUN, each cycle:
  - state_reg<=round(state_reg, C); idx<=idx+1.
  - C = {4'(15-idx), idx[3:0]}. Sequence for 12 rounds: F0,E1,D2,C3,B4,A5,96,87,78,69,5A,4B.
  - When the round with idx=11 is applied, go to DONE.
- DONE: done_o=1 for exactly one cycle; state_o=state_reg. Next state is IDLE, or RUN if start_i=1 (back-to-back accept).
- ready_o=1 in IDLE and DONE. busy_o=1 in RUN only.
- Latency: start accepted on edge E0, rounds applied on E1..En, done_o high during the cycle after En. Accept-to-done is n cycles; issue interval is n+1 cycles.
- start_i while busy_o=1 is ignored: no queuing, no error.
- rounds_i and state_i are don't-care except in the accept cycle.
- rst=1 mid-RUN aborts immediately to reset values. No done_o is produced for the aborted request.
- state_o is registered (no combinational path from state_i). state_o updates only in the DONE transition.

Optional Feature:
- Macro ASCON_PERM_UNROLL2_EN.
- Defined:
  - Two `round` instances are chained per cycle with constants C(idx) and C(idx+1); idx advances by 2.
  - If the remaining round count is 1, the second instance is bypassed.
  - Latency is ceil(n/2) cycles: p^12=6, p^8=4, p^6=3.
- Undefined: single instance, one round per cycle as above.
- Handshake semantics are identical in both builds.

Decomposition:
- Package ascon_pkg:
  - STATE_W and MAX_ROUNDS.
  - FSM state enum (IDLE/RUN/DONE).
  - Round-constant function rc(idx).
  - Lane slice constants X0..X4 (bit ranges).
- Sub-module: the existing `round`, instanced once, or twice under the macro. No new sub-module.

Test Plan:
- Reset then rounds_i=12, state_i=0 -> done_o exactly 12 cycles after accept (6 with the macro). state_o equals the golden C-model p^12(0). Probed C sequence is F0..4B.
- rounds_i=6 -> C sequence 96,87,78,69,5A,4B; done 6 cycles after accept. rounds_i=8 -> C sequence B4..4B; done after 8 cycles.
- start_i held high through RUN with a second state_i -> second request ignored until DONE. Back-to-back accept in the DONE cycle yields the next done 13 cycles after the first done (12-round requests).
- rst pulsed at round 5 of p^12 -> next cycle state_o=0, ready_o=1, no done_o. A fresh p^12 then matches the golden value.
- rounds_i=0 and rounds_i=15 -> behave as 12 rounds; same result as rounds_i=12. rounds_i=1 -> one round with C=4B, done after 1 cycle.
- Macro build, rounds_i=7 -> 4 cycles, last cycle single round. Result equals the non-macro p^7 result.
